// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor_pkg
//  Purpose  : Shared types and constants for the bit-serial subtractor.
//             The package holds the FSM state enum, the default operand width
//             and a helper that sizes the bit counter.
//  Revision : 1.0  initial release
// ============================================================================
package serial_subtractor_pkg;

  // Default operand/result width in bits.
  localparam int WIDTH_DEFAULT = 8;

  // Controller states: waiting for a start, or shifting bits through.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bit counter width: ceil(log2(width+1)).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : serial_subtractor_pkg
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : full_subtractor
//  Purpose  : One-bit full subtractor (x - y - bin) formed from two
//             half-subtractor stages. The first stage subtracts y from x,
//             the second subtracts the incoming borrow from that partial
//             difference; either stage may generate the outgoing borrow.
//  Revision : 1.0  initial release
// ============================================================================
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic hs1_diff;
  logic hs1_borrow;
  logic hs2_borrow;

  // First half subtractor: x - y.
  assign hs1_diff   = x ^ y;
  assign hs1_borrow = ~x & y;

  // Second half subtractor: (x - y) - bin.
  assign diff       = hs1_diff ^ bin;
  assign hs2_borrow = ~hs1_diff & bin;

  // A borrow leaves the bit if either stage needed one.
  assign bout = hs1_borrow | hs2_borrow;

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial unsigned subtractor, d = a - b mod 2^WIDTH.
//             A start in IDLE captures the operands; one bit is processed per
//             clock (LSB first) through a single full_subtractor cell, and
//             after WIDTH bits done pulses for one cycle with d and the final
//             borrow (bout). Results hold until the next accepted start.
//  Options  : SERIAL_SUBTRACTOR_OVF_EN adds a registered signed-overflow
//             output (ovf), updated together with done.
//  Revision : 1.0  initial release
// ============================================================================
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [WIDTH-1:0]   a_sh;      // minuend, shifted right one bit per cycle
  logic [WIDTH-1:0]   b_sh;      // subtrahend, shifted right one bit per cycle
  logic               borrow;    // borrow carried between bit positions
  logic               bit_diff;
  logic               bit_borrow;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // Operand sign bits are kept aside because the shift registers lose them.
  logic               a_msb;
  logic               b_msb;
`endif

  // Per-bit arithmetic always works on the current LSBs of the shifters.
  full_subtractor u_bit (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (borrow),
    .diff (bit_diff),
    .bout (bit_borrow)
  );

  // Controller, datapath shifters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      borrow  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      d       <= '0;
      bout    <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      // done is a single-cycle pulse unless the last bit completes below.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            borrow  <= 1'b0;
            bit_cnt <= '0;
            d       <= '0;
            busy    <= 1'b1;
            state   <= RUN;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb   <= a[WIDTH-1];
            b_msb   <= b[WIDTH-1];
`endif
          end
        end

        RUN: begin
          // Difference bits enter at the MSB end so bit i lands at d[i]
          // after WIDTH shifts.
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          borrow  <= bit_borrow;
          d       <= {bit_diff, d[WIDTH-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            bout  <= bit_borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            // bit_diff is the result MSB being produced on this edge.
            ovf   <= (a_msb != b_msb) && (bit_diff != a_msb);
`endif
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : Self-checking bench for serial_subtractor (WIDTH = 8).
//             Stimulus pushes expected results into a queue; a monitor on
//             the falling clock edge pops and compares whenever done is seen.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   last_acc = -1000;
  int   done_cnt = 0;
  exp_t exp_q[$];
  exp_t last_exp;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Edge counter: after active edge k (and before the next) cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: plain modular and signed arithmetic.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int acc);
    exp_t e;
    int   sdiff;
    e.d    = W'(int'(x) - int'(y));
    e.bout = (int'(x) < int'(y));
    sdiff  = int'($signed(x)) - int'($signed(y));
    e.ovf  = (sdiff > 127) || (sdiff < -128);
    e.cyc  = acc + W;
    return e;
  endfunction

  // Drive one start pulse while the DUT is known idle; push the expectation.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x;
    b = y;
    start = 1'b1;
    last_acc = cyc + 1;
    exp_q.push_back(model(x, y, cyc + 1));
    last_exp = model(x, y, cyc + 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic wait_done();
    repeat (W + 1) @(posedge clk);
    #1;
  endtask

  // Monitor: busy profile, mutual exclusion, and result scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_timing", {31'd0, busy}, {31'd0, (cyc >= last_acc) && (cyc < last_acc + W)});
      if (busy && done) chk("busy_done_excl", 32'd1, 32'd0);
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("result_d", {24'd0, d}, {24'd0, e.d});
          chk("result_bout", {31'd0, bout}, {31'd0, e.bout});
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          chk("result_ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        chk("missing_done", 32'd0, 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset values, applied asynchronously before any clock edge.
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_d", {24'd0, d}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases.
    issue(8'h05, 8'h03); wait_done();
    chk("dir_05_03_d", {24'd0, d}, 32'h02);
    chk("dir_05_03_bout", {31'd0, bout}, 32'd0);
    issue(8'h03, 8'h05); wait_done();
    chk("dir_03_05_d", {24'd0, d}, 32'hFE);
    chk("dir_03_05_bout", {31'd0, bout}, 32'd1);
    issue(8'hFF, 8'hFF); wait_done();
    chk("dir_ff_ff_d", {24'd0, d}, 32'h00);
    chk("dir_ff_ff_bout", {31'd0, bout}, 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    issue(8'h80, 8'h01); wait_done();
    chk("ovf_80_01_d", {24'd0, d}, 32'h7F);
    chk("ovf_80_01", {31'd0, ovf}, 32'd1);
    issue(8'h05, 8'h03); wait_done();
    chk("ovf_05_03", {31'd0, ovf}, 32'd0);
`endif

    // Results hold in IDLE.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_d", {24'd0, d}, {24'd0, last_exp.d});
    chk("hold_bout", {31'd0, bout}, {31'd0, last_exp.bout});

    // start during RUN is ignored.
    n = done_cnt;
    issue(8'h9C, 8'h3A);
    repeat (2) @(posedge clk);
    #1;
    a = 8'h11;
    b = 8'h22;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (W + 2) @(posedge clk);
    #1;
    chk("ignored_start_one_done", done_cnt - n, 1);
    chk("ignored_start_d", {24'd0, d}, 32'h62);

    // Reset while bit 4 is in progress.
    issue(8'hA7, 8'h5B);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
    chk("midrun_rst_done", {31'd0, done}, 32'd0);
    chk("midrun_rst_d", {24'd0, d}, 32'd0);
    chk("midrun_rst_bout", {31'd0, bout}, 32'd0);
    exp_q.delete();
    last_acc = -1000;
    @(posedge clk);
    #3 rst_n = 1'b1;
    n = done_cnt;
    repeat (2 * W) @(posedge clk);
    #1;
    chk("no_done_after_rst", done_cnt - n, 0);

    // start held high: back-to-back operations WIDTH+1 cycles apart.
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] x, y;
      x = W'($urandom);
      y = W'($urandom);
      a = x;
      b = y;
      start = 1'b1;
      last_acc = cyc + 1;
      exp_q.push_back(model(x, y, cyc + 1));
      @(posedge clk);
      #1;
      if (i == 3) start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      if (i != 3) begin
        repeat (W) @(posedge clk);
        #1;
      end
    end
    wait_done();

    // Randomised operations with random idle gaps.
    for (int i = 0; i < 24; i++) begin
      issue(W'($urandom), W'($urandom));
      wait_done();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_subtractor
`default_nettype wire
